// File: rtl/vref_seq_pkg.sv
// Shared types and default phase lengths for the reference-voltage sequencer.
package vref_seq_pkg;

  localparam int T_PRE_DEF   = 15;
  localparam int T_DIODE_DEF = 7;
  localparam int T_BIG_DEF   = 7;
  localparam int T_CHG_DEF   = 5;
  localparam int N_OUT_DEF   = 14;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_PRECHARGE = 4'd1,
    S_BLANK     = 4'd2,
    S_DIODE     = 4'd3,
    S_BIGDIODE  = 4'd4,
    S_HCHARGE   = 4'd5,
    S_LCHARGE   = 4'd6,
    S_OUTPUT    = 4'd7,
    S_HALT      = 4'd8
  } state_e;

  typedef struct packed {
    logic pi1;
    logic pi2;
    logic pii1;
    logic pii2;
    logic pa;
    logic pb;
    logic pc;
    logic pd;
    logic s_bg2cmp;
    logic pre_chrg;
  } sw_t;

  // Switch pattern held for the whole of a phase.
  function automatic sw_t phase_sw(input state_e st);
    sw_t sw;
    sw = '0;
    case (st)
      S_PRECHARGE: begin
        sw.pre_chrg = 1'b1;
        sw.pb       = 1'b1;
        sw.pc       = 1'b1;
        sw.pd       = 1'b1;
        sw.s_bg2cmp = 1'b1;
      end
      S_DIODE: begin
        sw.pii1 = 1'b1;
        sw.pii2 = 1'b1;
      end
      S_BIGDIODE: begin
        sw.pi1 = 1'b1;
        sw.pi2 = 1'b1;
      end
      S_HCHARGE: begin
        sw.pa = 1'b1;
        sw.pb = 1'b1;
      end
      S_LCHARGE: begin
        sw.pa = 1'b1;
        sw.pc = 1'b1;
      end
      S_OUTPUT: begin
        sw.pa = 1'b1;
        sw.pb = 1'b1;
        sw.pc = 1'b1;
        sw.pd = 1'b1;
      end
      default: sw = '0;
    endcase
    return sw;
  endfunction

  // Conversion loop order; step 6 is the BIGDIODE that follows OUTPUT.
  function automatic state_e conv_phase(input logic [2:0] step);
    case (step)
      3'd0:    return S_DIODE;
      3'd1:    return S_HCHARGE;
      3'd2:    return S_BIGDIODE;
      3'd3:    return S_DIODE;
      3'd4:    return S_LCHARGE;
      3'd5:    return S_OUTPUT;
      3'd6:    return S_BIGDIODE;
      default: return S_DIODE;
    endcase
  endfunction

endpackage

// File: rtl/vref_seq_timer.sv
// Phase timer: loads a length on phase entry, counts down to zero without
// wrapping, and flags the final cycle of the phase with done.
module vref_seq_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Reload on phase entry, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/vref_seq.sv
// Bandgap reference sequencer: precharge, bias-trim setup loop, then the
// repeating conversion loop; every phase change passes through one BLANK.
// Optional macro VREF_CHOP_EN: toggle comparator chop phases on each DIODE exit.
module vref_seq
  import vref_seq_pkg::*;
#(
  parameter int CNT_W    = 6,
  parameter int T_PRE    = T_PRE_DEF,
  parameter int T_DIODE  = T_DIODE_DEF,
  parameter int T_BIG    = T_BIG_DEF,
  parameter int T_CHG    = T_CHG_DEF,
  parameter int N_OUT    = N_OUT_DEF,
  parameter int TRIM_W   = 4,
  parameter int STABLE_N = 3,
  parameter int MAX_ITER = 31
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              cmp,
  output logic              pi1,
  output logic              pi2,
  output logic              pii1,
  output logic              pii2,
  output logic              pa,
  output logic              pb,
  output logic              pc,
  output logic              pd,
  output logic              s_bg2cmp,
  output logic              src_n,
  output logic              snk,
  output logic              cmp_p1,
  output logic              cmp_p2,
  output logic              pre_chrg,
  output logic              setup_bias,
  output logic              valid,
  output logic              err,
  output logic [TRIM_W-1:0] trim
);

  localparam int ITER_W = $clog2(MAX_ITER + 1);
  localparam int DITH_W = $clog2(STABLE_N + 1);
  localparam logic [TRIM_W-1:0] TRIM_MAX = {TRIM_W{1'b1}};
  localparam logic [TRIM_W-1:0] TRIM_MID = {1'b1, {(TRIM_W-1){1'b0}}};

  if (T_PRE < 1 || T_PRE >= (1 << CNT_W) || T_DIODE < 1 || T_DIODE >= (1 << CNT_W) ||
      T_BIG < 1 || T_BIG >= (1 << CNT_W) || T_CHG < 1 || T_CHG >= (1 << CNT_W) ||
      N_OUT < 1 || N_OUT >= (1 << CNT_W)) begin : g_bad_len
    $error("vref_seq: phase length does not fit the CNT_W phase counter");
  end

  state_e state_d, state_q, queued_d, queued_q;
  logic [2:0] step_d, step_q, nstep_s;
  logic setup_done_d, setup_done_q, prev_smp_d, prev_smp_q, rail_d, rail_q;
  logic [DITH_W-1:0] dith_d, dith_q, dith_nxt_s;
  logic [ITER_W-1:0] iter_d, iter_q, iter_nxt_s;
  logic [TRIM_W-1:0] trim_d, trim_q, trim_nxt_s;
  logic rail_nxt_s, pend_src_d, pend_src_q, pend_snk_d, pend_snk_q;
  sw_t  sw_d, sw_q;
  logic src_n_d, src_n_q, snk_d, snk_q, setup_bias_d, setup_bias_q;
  logic valid_d, valid_q, err_d, err_q, cmp_p1_d, cmp_p1_q, cmp_p2_d, cmp_p2_q;
  logic chop_tgl_s, done_s, load_s;
  logic [CNT_W-1:0] load_val_s;

  // Candidate results of a comparator sample and of a loop-step advance.
  always_comb begin
    if (cmp) begin
      trim_nxt_s = (trim_q == TRIM_MAX) ? trim_q : trim_q + TRIM_W'(1);
    end else begin
      trim_nxt_s = (trim_q == '0) ? trim_q : trim_q - TRIM_W'(1);
    end
    rail_nxt_s = (trim_nxt_s == TRIM_MAX) || (trim_nxt_s == '0);
    dith_nxt_s = (cmp != prev_smp_q) ? dith_q + DITH_W'(1) : dith_q;
    iter_nxt_s = (iter_q == ITER_W'(MAX_ITER)) ? iter_q : iter_q + ITER_W'(1);
    nstep_s    = (step_q == 3'd6) ? 3'd0 : step_q + 3'd1;
  end

  // Phase sequencing, setup trim loop and HALT detection.
  always_comb begin
    state_d      = state_q;
    queued_d     = queued_q;
    step_d       = step_q;
    setup_done_d = setup_done_q;
    prev_smp_d   = prev_smp_q;
    rail_d       = rail_q;
    dith_d       = dith_q;
    iter_d       = iter_q;
    trim_d       = trim_q;
    pend_src_d   = pend_src_q;
    pend_snk_d   = pend_snk_q;
    if (!en) begin
      state_d      = S_IDLE;
      setup_done_d = 1'b0;
      step_d       = 3'd0;
      pend_src_d   = 1'b0;
      pend_snk_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d      = S_PRECHARGE;
          trim_d       = TRIM_MID;
          prev_smp_d   = 1'b0;
          rail_d       = 1'b0;
          dith_d       = '0;
          iter_d       = '0;
          setup_done_d = 1'b0;
          step_d       = 3'd0;
        end
        S_PRECHARGE: begin
          if (done_s) begin
            state_d  = S_BLANK;
            queued_d = S_DIODE;
          end else begin
            state_d = S_PRECHARGE;
          end
        end
        S_BLANK: begin
          state_d    = queued_q;
          pend_src_d = 1'b0;
          pend_snk_d = 1'b0;
        end
        S_BIGDIODE: begin
          if (done_s && !setup_done_q) begin
            state_d    = S_BLANK;
            trim_d     = trim_nxt_s;
            rail_d     = rail_nxt_s;
            prev_smp_d = cmp;
            dith_d     = dith_nxt_s;
            iter_d     = iter_nxt_s;
            if (rail_nxt_s && rail_q) begin
              queued_d = S_HALT;
            end else if (dith_nxt_s >= DITH_W'(STABLE_N)) begin
              setup_done_d = 1'b1;
              step_d       = 3'd0;
              queued_d     = S_DIODE;
              pend_src_d   = cmp;
              pend_snk_d   = !cmp;
            end else if (iter_nxt_s >= ITER_W'(MAX_ITER)) begin
              queued_d = S_HALT;
            end else begin
              queued_d   = S_DIODE;
              pend_src_d = cmp;
              pend_snk_d = !cmp;
            end
          end else if (done_s) begin
            state_d  = S_BLANK;
            queued_d = conv_phase(nstep_s);
            step_d   = nstep_s;
          end else begin
            state_d = S_BIGDIODE;
          end
        end
        S_DIODE, S_HCHARGE, S_LCHARGE, S_OUTPUT: begin
          if (done_s && state_q == S_DIODE && !setup_done_q) begin
            state_d  = S_BLANK;
            queued_d = S_BIGDIODE;
          end else if (done_s) begin
            state_d  = S_BLANK;
            queued_d = conv_phase(nstep_s);
            step_d   = nstep_s;
          end else begin
            state_d = state_q;
          end
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Phase length loaded into the timer whenever the phase changes.
  always_comb begin
    load_s = (state_d != state_q);
    case (state_d)
      S_PRECHARGE:          load_val_s = CNT_W'(T_PRE);
      S_DIODE:              load_val_s = CNT_W'(T_DIODE);
      S_BIGDIODE:           load_val_s = CNT_W'(T_BIG);
      S_HCHARGE, S_LCHARGE: load_val_s = CNT_W'(T_CHG);
      S_OUTPUT:             load_val_s = CNT_W'(N_OUT);
      default:              load_val_s = '0;
    endcase
  end

  vref_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load_s),
    .load_val (load_val_s),
    .done     (done_s)
  );

`ifdef VREF_CHOP_EN
  assign chop_tgl_s = en && (state_q == S_DIODE) && done_s;
`else
  assign chop_tgl_s = 1'b0;
`endif

  // Output values for the coming cycle, decoded from the next phase.
  always_comb begin
    sw_d         = phase_sw(state_d);
    src_n_d      = (state_q == S_BLANK) && (state_d == S_DIODE) && pend_src_q;
    snk_d        = (state_q == S_BLANK) && (state_d == S_DIODE) && pend_snk_q;
    setup_bias_d = !setup_done_d && (state_d inside {S_PRECHARGE, S_BLANK, S_DIODE, S_BIGDIODE});
    valid_d      = en && (valid_q || (state_d == S_OUTPUT));
    err_d        = (state_d == S_HALT);
    cmp_p1_d     = chop_tgl_s ? !cmp_p1_q : cmp_p1_q;
    cmp_p2_d     = chop_tgl_s ? !cmp_p2_q : cmp_p2_q;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      queued_q     <= S_IDLE;
      step_q       <= 3'd0;
      setup_done_q <= 1'b0;
      prev_smp_q   <= 1'b0;
      rail_q       <= 1'b0;
      dith_q       <= '0;
      iter_q       <= '0;
      trim_q       <= TRIM_MID;
      pend_src_q   <= 1'b0;
      pend_snk_q   <= 1'b0;
      sw_q         <= '0;
      src_n_q      <= 1'b0;
      snk_q        <= 1'b0;
      setup_bias_q <= 1'b0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      cmp_p1_q     <= 1'b1;
      cmp_p2_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      queued_q     <= queued_d;
      step_q       <= step_d;
      setup_done_q <= setup_done_d;
      prev_smp_q   <= prev_smp_d;
      rail_q       <= rail_d;
      dith_q       <= dith_d;
      iter_q       <= iter_d;
      trim_q       <= trim_d;
      pend_src_q   <= pend_src_d;
      pend_snk_q   <= pend_snk_d;
      sw_q         <= sw_d;
      src_n_q      <= src_n_d;
      snk_q        <= snk_d;
      setup_bias_q <= setup_bias_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      cmp_p1_q     <= cmp_p1_d;
      cmp_p2_q     <= cmp_p2_d;
    end
  end

  assign pi1        = sw_q.pi1;
  assign pi2        = sw_q.pi2;
  assign pii1       = sw_q.pii1;
  assign pii2       = sw_q.pii2;
  assign pa         = sw_q.pa;
  assign pb         = sw_q.pb;
  assign pc         = sw_q.pc;
  assign pd         = sw_q.pd;
  assign s_bg2cmp   = sw_q.s_bg2cmp;
  assign pre_chrg   = sw_q.pre_chrg;
  assign src_n      = src_n_q;
  assign snk        = snk_q;
  assign setup_bias = setup_bias_q;
  assign valid      = valid_q;
  assign err        = err_q;
  assign cmp_p1     = cmp_p1_q;
  assign cmp_p2     = cmp_p2_q;
  assign trim       = trim_q;

endmodule

// File: tb/tb_vref_seq.sv
// Bench for vref_seq: scenario table plus random setup runs, each checked
// cycle by cycle against a phase-segment model of the sequence.
module tb_vref_seq;

  localparam int T_PRE = 15, T_DIODE = 7, T_BIG = 7, T_CHG = 5, N_OUT = 14;
  localparam int STABLE_N = 3, MAX_ITER = 31;
  localparam int K_PRE = 0, K_BLANK = 1, K_DIODE = 2, K_BIG = 3, K_H = 4, K_L = 5, K_OUT = 6, K_HALT = 7;

  logic clk, reset_n, en, cmp;
  logic pi1, pi2, pii1, pii2, pa, pb, pc, pd, s_bg2cmp, src_n, snk;
  logic cmp_p1, cmp_p2, pre_chrg, setup_bias, valid, err;
  logic [3:0] trim;

  vref_seq dut (
    .clk(clk), .reset_n(reset_n), .en(en), .cmp(cmp),
    .pi1(pi1), .pi2(pi2), .pii1(pii1), .pii2(pii2),
    .pa(pa), .pb(pb), .pc(pc), .pd(pd), .s_bg2cmp(s_bg2cmp),
    .src_n(src_n), .snk(snk), .cmp_p1(cmp_p1), .cmp_p2(cmp_p2),
    .pre_chrg(pre_chrg), .setup_bias(setup_bias), .valid(valid), .err(err),
    .trim(trim)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic pi1, pi2, pii1, pii2, pa, pb, pc, pd, s_bg2cmp, src_n, snk;
    logic cmp_p1, cmp_p2, pre_chrg, setup_bias, valid, err;
    logic [3:0] trim;
  } obs_t;

  typedef struct {
    string      name;
    bit [31:0]  bits;   // sample values, bit 0 first
    int         nbits;  // samples beyond this are random
    int         loops;  // conversion loops after setup
    int         exp_trim;
    bit         exp_err;
  } scen_t;

  int   checks = 0, errors = 0;
  obs_t exp_q[$];
  bit   cmp_q[$];
  bit   m_chop, m_setup, m_valid;
  int   m_trim;

  function automatic obs_t sample_dut();
    obs_t o;
    o = '{pi1, pi2, pii1, pii2, pa, pb, pc, pd, s_bg2cmp, src_n, snk,
          cmp_p1, cmp_p2, pre_chrg, setup_bias, valid, err, trim};
    return o;
  endfunction

  function automatic int plen(input int kind);
    case (kind)
      K_PRE:      return T_PRE;
      K_DIODE:    return T_DIODE;
      K_BIG:      return T_BIG;
      K_H, K_L:   return T_CHG;
      K_OUT:      return N_OUT;
      K_HALT:     return 5;
      default:    return 1;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Append one phase of expected cycles; pulses land on the first cycle.
  task automatic seg(input int kind, input bit last_cmp, input bit p_src, input bit p_snk);
    obs_t o;
    int len;
    len = plen(kind);
    for (int i = 0; i < len; i++) begin
      o = '0;
      case (kind)
        K_PRE:   begin o.pre_chrg = 1; o.pb = 1; o.pc = 1; o.pd = 1; o.s_bg2cmp = 1; end
        K_DIODE: begin o.pii1 = 1; o.pii2 = 1; end
        K_BIG:   begin o.pi1 = 1; o.pi2 = 1; end
        K_H:     begin o.pa = 1; o.pb = 1; end
        K_L:     begin o.pa = 1; o.pc = 1; end
        K_OUT:   begin o.pa = 1; o.pb = 1; o.pc = 1; o.pd = 1; end
        default: ;
      endcase
      if (kind == K_OUT) m_valid = 1;
      o.valid      = m_valid;
      o.err        = (kind == K_HALT);
      o.setup_bias = m_setup && (kind != K_HALT);
      o.trim       = 4'(m_trim);
      o.cmp_p1     = !m_chop;
      o.cmp_p2     = m_chop;
      if (i == 0) begin o.src_n = p_src; o.snk = p_snk; end
      exp_q.push_back(o);
      cmp_q.push_back((kind == K_BIG && i == len - 1) ? last_cmp : 1'($urandom));
    end
`ifdef VREF_CHOP_EN
    if (kind == K_DIODE) m_chop = !m_chop;
`endif
  endtask

  // Expected trace for one run from reset release with en held high.
  task automatic build(input bit [31:0] bits, input int nbits, input int loops, output int result);
    int it, d, nt;
    bit prev, rail, nrail, s, ps, pk;
    int conv_k[14];
    conv_k = '{K_DIODE, K_BLANK, K_H, K_BLANK, K_BIG, K_BLANK, K_DIODE, K_BLANK,
               K_L, K_BLANK, K_OUT, K_BLANK, K_BIG, K_BLANK};
    exp_q.delete(); cmp_q.delete();
    m_trim = 8; m_chop = 0; m_setup = 1; m_valid = 0;
    it = 0; d = 0; prev = 0; rail = 0; ps = 0; pk = 0; result = 0;
    seg(K_PRE, 0, 0, 0);
    seg(K_BLANK, 0, 0, 0);
    while (result == 0) begin
      s = (it < nbits) ? bits[it[4:0]] : 1'($urandom);
      seg(K_DIODE, 0, ps, pk);
      seg(K_BLANK, 0, 0, 0);
      seg(K_BIG, s, 0, 0);
      it++;
      nt = s ? ((m_trim < 15) ? m_trim + 1 : 15) : ((m_trim > 0) ? m_trim - 1 : 0);
      nrail = (nt == 0) || (nt == 15);
      if (s != prev) d++;
      prev = s;
      if (nrail && rail) result = 2;
      else if (d >= STABLE_N) result = 1;
      else if (it >= MAX_ITER) result = 2;
      rail = nrail;
      m_trim = nt;
      ps = (result != 2) && s;
      pk = (result != 2) && !s;
      if (result == 1) m_setup = 0;
      seg(K_BLANK, 0, 0, 0);
    end
    if (result == 2) begin
      seg(K_HALT, 0, 0, 0);
    end else begin
      for (int l = 0; l < loops; l++) begin
        for (int j = 0; j < 14; j++) begin
          seg(conv_k[j], 1'($urandom), ps, pk);
          ps = 0; pk = 0;
        end
      end
    end
  endtask

  // Replay the trace; stop early at index stop_at when it is not negative.
  task automatic run(input string name, input int stop_at);
    obs_t act;
    logic [6:0] grp, prev_grp;
    prev_grp = '0;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(posedge clk);
      #1;
      act = sample_dut();
      checks++;
      if (act !== exp_q[k]) begin
        errors++;
        if (errors < 30) $display("FAIL %s trace[%0d] got %h want %h", name, k, act, exp_q[k]);
      end
      grp = {pre_chrg, pii1, pi1, pa, pb, pc, pd};
      if (prev_grp != 7'd0 && grp != 7'd0) begin
        checks++;
        if (grp != prev_grp) begin
          errors++;
          $display("FAIL %s blank_gap cyc %0d got %b after %b want BLANK between", name, k, grp, prev_grp);
        end
      end
      prev_grp = grp;
      cmp = cmp_q[k];
      if (k == stop_at) break;
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
    en      = 1'b1;
    cmp     = 1'b0;
  endtask

  // Drop en, confirm IDLE outputs, then hold the block in reset.
  task automatic drop_en(input string name);
    obs_t act;
    en = 1'b0;
    @(posedge clk);
    #1;
    act = sample_dut();
    act.trim = '0; act.cmp_p1 = 1'b0; act.cmp_p2 = 1'b0;
    check({name, "_en_low_idle"}, 32'(act), 32'd0);
    reset_n = 1'b0;
    #1;
  endtask

  scen_t tbl[6];
  obs_t  rst_obs, act;
  int    res, stop;

  initial begin
    tbl[0] = '{"alt101",   32'h0000_0005, 3,  2, 9,  1'b0};
    tbl[1] = '{"hold1",    32'hFFFF_FFFF, 32, 0, 15, 1'b1};
    tbl[2] = '{"hold0",    32'h0000_0000, 32, 0, 0,  1'b1};
    tbl[3] = '{"p1101",    32'h0000_000B, 4,  1, 10, 1'b0};
    tbl[4] = '{"p0101",    32'h0000_000A, 4,  1, 8,  1'b0};
    tbl[5] = '{"railback", 32'h0000_017F, 9,  1, 15, 1'b0};
    rst_obs = '0;
    rst_obs.cmp_p1 = 1'b1;
    rst_obs.trim   = 4'd8;

    reset_n = 1'b0; en = 1'b0; cmp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_values", 32'(sample_dut()), 32'(rst_obs));

    foreach (tbl[i]) begin
      build(tbl[i].bits, tbl[i].nbits, tbl[i].loops, res);
      release_reset();
      run(tbl[i].name, -1);
      check({tbl[i].name, "_trim"}, 32'(trim), 32'(tbl[i].exp_trim));
      check({tbl[i].name, "_err"}, 32'(err), 32'(tbl[i].exp_err));
      check({tbl[i].name, "_valid"}, 32'(valid), 32'(tbl[i].loops > 0));
      drop_en(tbl[i].name);
    end

    for (int r = 0; r < 4; r++) begin
      build(32'd0, 0, 1, res);
      release_reset();
      run("random", -1);
      check("random_err", 32'(err), 32'(res == 2));
      drop_en("random");
    end

    // Asynchronous reset in the middle of an OUTPUT phase.
    build(32'h0000_0005, 3, 1, res);
    stop = -1;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (stop < 0 && exp_q[k].valid) stop = k + 3;
    end
    release_reset();
    run("reset_in_output", stop);
    check("output_reached", 32'({pa, pb, pc, pd, valid}), 32'h1F);
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_mid_output", 32'(sample_dut()), 32'(rst_obs));
    en = 1'b0;
    @(posedge clk);
    #1;
    check("reset_held", 32'(sample_dut()), 32'(rst_obs));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vref_seq.md
VREF_SEQ -- requirements
Module: vref_seq

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
- CNT_W, 6: phase-counter width.
- T_PRE, 15: precharge cycles.
- T_DIODE, 7: small-diode phase cycles.
- T_BIG, 7: big-diode phase cycles.
- T_CHG, 5: H/L charge cycles.
- N_OUT, 14: output-hold cycles.
- TRIM_W, 4: bias trim width.
- STABLE_N, 3: trim dithers to end setup.
- MAX_ITER, 31: setup iteration limit.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning. Clock and reset come first:
- clk, in, 1: single clock.
- reset_n, in, 1: asynchronous active-low reset.
- en, in, 1: run request.
- cmp, in, 1: comparator decision.
- pi1, pi2, pii1, pii2, out, 1 each: diode switch phases.
- pa, pb, pc, pd, out, 1 each: cap-array switches.
- s_bg2cmp, out, 1: route bandgap to comparator.
- src_n, snk, out, 1 each: bias source/sink pulses.
- cmp_p1, cmp_p2, out, 1 each: comparator chop phases.
- pre_chrg, setup_bias, valid, err, out, 1 each.
- trim, out, TRIM_W: bias trim code.
REQ-003 SHALL use one clock (clk) and an asynchronous active-low reset (reset_n).

Function
REQ-004 States SHALL be IDLE, PRECHARGE, BLANK, DIODE, BIGDIODE, HCHARGE, LCHARGE, OUTPUT and HALT.
REQ-005 IDLE: on en=1, go to PRECHARGE; en=0 in any state SHALL return to IDLE next cycle with all switches 0 and valid=0.
REQ-006 PRECHARGE: hold pre_chrg=1, setup_bias=1, pb=pc=pd=1, s_bg2cmp=1 for exactly T_PRE cycles, then go to BLANK.
REQ-007 BLANK: one cycle with pa..pd, pi2, pii2, src_n and snk all 0, then enter the queued next phase; every phase change SHALL pass through BLANK.
REQ-008 DIODE: pii1=pii2=1 for T_DIODE cycles. BIGDIODE: pi1=pi2=1 for T_BIG cycles; cmp is sampled on the last BIGDIODE cycle.
REQ-009 Setup loop is DIODE->BIGDIODE, repeated:
- sample 1: src_n=1 for one cycle and trim+1.
- sample 0: snk=1 for one cycle and trim-1.
- trim SHALL saturate at 0 and 2^TRIM_W-1.
REQ-010 A dither is a sample differing from the previous sample. After STABLE_N dithers, setup_bias SHALL go to 0 and the block enters the conversion loop.
REQ-011 Conversion loop: DIODE->HCHARGE->BIGDIODE->DIODE->LCHARGE->OUTPUT, repeated while en=1.
- HCHARGE: pa=pb=1 for T_CHG cycles.
- LCHARGE: pa=pc=1 for T_CHG cycles.
REQ-012 OUTPUT: pa..pd=1 for N_OUT cycles, then continue to BIGDIODE. valid SHALL rise on the first OUTPUT cycle and stay 1 until en=0 or reset.
REQ-013 Setup SHALL go to HALT with err=1 and all switches 0 if either:
- MAX_ITER iterations pass without completing setup, or
- trim stays at a saturation rail on two consecutive samples.
REQ-014 HALT exits only via en=0, which also clears err.
REQ-015 Phase counters SHALL be CNT_W bits and SHALL NOT wrap; T_* SHALL satisfy 1 <= T < 2^CNT_W (elaboration check).

Reset
REQ-016 While reset_n=0, all outputs SHALL be 0 except cmp_p1=1, and trim SHALL be 2^(TRIM_W-1); state SHALL be IDLE.
REQ-017 reset_n asserting mid-phase SHALL force the reset values in the same cycle; en sampled 1 at release SHALL start PRECHARGE on the first clk edge.

Configuration
REQ-018 With VREF_CHOP_EN defined, cmp_p1 and cmp_p2 SHALL toggle (always complementary) on every DIODE->BLANK exit. Without VREF_CHOP_EN, they SHALL be fixed at cmp_p1=1, cmp_p2=0.

Structure
REQ-019 Package vref_seq_pkg SHALL hold the state enum and the default T_*/N_OUT constants.
REQ-020 Sub-module vref_seq_timer (load, count down, done pulse; width CNT_W) SHALL time all phases.

Verification
REQ-021 Defaults, en=1 after reset -> pre_chrg high for 15 cycles, a BLANK cycle, then pii2 high for 7 cycles.
REQ-022 cmp alternating 1,0,1 on BIGDIODE samples -> trim 8->9->8->9, then setup_bias=0 and HCHARGE pa=pb=1 for 5 cycles.
REQ-023 Full conversion -> valid rises on the first OUTPUT cycle; pa..pd=1 for 14 cycles; no two phase groups are ever high on adjacent cycles without a BLANK between them.
REQ-024 cmp held 1 -> trim saturates at 15, then err=1 and state HALT; en low -> err clears and state returns to IDLE.
REQ-025 reset_n pulsed low during OUTPUT -> all outputs zero, trim=8 and valid=0 in the same cycle. With VREF_CHOP_EN defined, cmp_p1/p2 toggle per DIODE exit; without it they stay 1/0.
